// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: decodes opcode/funct from the IR and
// sequences the datapath enables, mux selects and ALU operation each cycle.
module mips_mc_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_ctrl,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTEX     = 4'd6,
    RTWB     = 4'd7,
    BEQ      = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;

  typedef struct packed {
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;

  state_t     state;
  state_t     next_state;
  ctrl_t      ctrl_q;
  logic [2:0] funct_alu;
  logic       funct_ok;
  logic       op_legal;

  // Moore control word for each state; everything not listed stays at the idle default.
  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    case (s)
      FETCH:  begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  c.iord = 1'b1;
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
      RTEX:   c.alu_src_a = 1'b1;
      RTWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      BEQ: begin
        c.alu_src_a  = 1'b1;
        c.alu_ctrl   = ALU_CMP;
        c.pc_src     = 2'b01;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    funct_alu = ALU_ADD;
    funct_ok  = 1'b1;
    case (funct)
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100111: funct_alu = ALU_NOR;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_RTYPE:                            op_legal = funct_ok;
      default:                             op_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        if (!op_legal) begin
          next_state = ILLEGAL_HALT ? HALT : FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_RTYPE:     next_state = RTEX;
            OP_BEQ:       next_state = BEQ;
            OP_ADDI:      next_state = ADDIEX;
            default:      next_state = JUMP;
          endcase
        end
      end
      MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next_state = MEMWB;
      RTEX:   next_state = RTWB;
      ADDIEX: next_state = ADDIWB;
      HALT:   next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  // The control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state  <= FETCH;
      ctrl_q <= ctrl_for(FETCH);
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_for(next_state);
    end
  end

  // NOTE: reset is synchronous, so enables are gated with rst combinationally to suppress
  // any write in the cycle where reset is being applied.
  assign alu_ctrl      = (state == RTEX) ? funct_alu : ctrl_q.alu_ctrl;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign pc_en         = !rst && (ctrl_q.pc_write || (ctrl_q.branch && zero));
  assign iord          = ctrl_q.iord;
  assign mem_write     = !rst && ctrl_q.mem_write;
  assign ir_write      = !rst && ctrl_q.ir_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_write     = !rst && ctrl_q.reg_write;
  assign instr_done    = !rst && ctrl_q.instr_done;
  assign illegal_instr = !rst && (state == DECODE) && !op_legal;
  assign state_dbg     = state;

endmodule
